// File: rtl/lcd_spi_writer_if.sv
// Byte-request handshake between the command/data generator
// and the LCD SPI writer.
interface lcd_spi_writer_if;
  logic [8:0] data;
  logic       en_write;
  logic       wr_done;
  logic       busy;

  modport master (
    output data,
    output en_write,
    input  wr_done,
    input  busy
  );

  modport slave (
    input  data,
    input  en_write,
    output wr_done,
    output busy
  );
endinterface

// File: rtl/lcd_spi_writer.sv
// SPI mode-0 byte transmitter for a 4-wire ST7789-class LCD,
// one wr_done pulse per byte, then a fixed idle gap.
module lcd_spi_writer #(
  parameter int SCLK_DIV   = 2,
  parameter int GAP_CYCLES = 4
) (
  input  logic               sys_clk,
  input  logic               sys_rst_n,
  lcd_spi_writer_if.slave    wr,
  output logic               lcd_sclk,
  output logic               lcd_mosi,
  output logic               lcd_dc,
  output logic               lcd_cs_n
);

  localparam int GW = $clog2(GAP_CYCLES + 1);
  localparam logic [3:0]    HMAX = 4'(SCLK_DIV - 1);
  localparam logic [GW-1:0] GMAX = GW'(GAP_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE,
    GAP
  } state_t;

  state_t        state;
  logic [7:0]    shreg;
  logic [3:0]    hcnt;
  logic [2:0]    bcnt;
  logic [GW-1:0] gcnt;

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state      <= IDLE;
      shreg      <= '0;
      hcnt       <= '0;
      bcnt       <= '0;
      gcnt       <= '0;
      wr.wr_done <= 1'b0;
      wr.busy    <= 1'b0;
      lcd_sclk   <= 1'b0;
      lcd_mosi   <= 1'b0;
      lcd_dc     <= 1'b0;
      lcd_cs_n   <= 1'b1;
    end else begin
      wr.wr_done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (wr.en_write) begin
            shreg    <= wr.data[7:0];
            lcd_dc   <= wr.data[8];
            lcd_mosi <= wr.data[7];
            lcd_cs_n <= 1'b0;
            hcnt     <= '0;
            bcnt     <= '0;
            wr.busy  <= 1'b1;
            state    <= SHIFT;
          end else begin
            lcd_cs_n <= 1'b1;
          end
        end
        SHIFT: begin
          if (hcnt == HMAX) begin
            hcnt <= '0;
            if (!lcd_sclk) begin
              lcd_sclk <= 1'b1;
            end else begin
              lcd_sclk <= 1'b0;
              if (bcnt == 3'd7) begin
                wr.wr_done <= 1'b1;
                state      <= DONE;
              end else begin
                lcd_mosi <= shreg[6];
                shreg    <= {shreg[6:0], 1'b0};
                bcnt     <= bcnt + 3'd1;
              end
            end
          end else begin
            hcnt <= hcnt + 4'd1;
          end
        end
        DONE: begin
          gcnt  <= '0;
          state <= GAP;
        end
        GAP: begin
          if (gcnt == GMAX) begin
            // CS already reflects the request for the first IDLE cycle
            lcd_cs_n <= ~wr.en_write;
            wr.busy  <= 1'b0;
            state    <= IDLE;
          end else begin
            gcnt <= gcnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lcd_spi_writer.sv
// Directed bench for lcd_spi_writer: default timing instance
// plus a SCLK_DIV=1 / GAP_CYCLES=2 instance.
module tb_lcd_spi_writer;

  logic       sys_clk;
  logic       sys_rst_n;
  logic [8:0] data_d [2];
  logic [1:0] en_d;
  wire  [1:0] sclk, mosi, dc, csn, done_s, busy_s;

  lcd_spi_writer_if bus0 ();
  lcd_spi_writer_if bus1 ();

  assign bus0.data     = data_d[0];
  assign bus0.en_write = en_d[0];
  assign bus1.data     = data_d[1];
  assign bus1.en_write = en_d[1];
  assign done_s[0]     = bus0.wr_done;
  assign done_s[1]     = bus1.wr_done;
  assign busy_s[0]     = bus0.busy;
  assign busy_s[1]     = bus1.busy;

  lcd_spi_writer #(.SCLK_DIV(2), .GAP_CYCLES(4)) dut0 (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .wr        (bus0.slave),
    .lcd_sclk  (sclk[0]),
    .lcd_mosi  (mosi[0]),
    .lcd_dc    (dc[0]),
    .lcd_cs_n  (csn[0])
  );

  lcd_spi_writer #(.SCLK_DIV(1), .GAP_CYCLES(2)) dut1 (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .wr        (bus1.slave),
    .lcd_sclk  (sclk[1]),
    .lcd_mosi  (mosi[1]),
    .lcd_dc    (dc[1]),
    .lcd_cs_n  (csn[1])
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  int cyc = 0;
  always @(posedge sys_clk) cyc <= cyc + 1;

  // LCD-side receiver: shift in MOSI on every SCLK rise
  logic [8:0] cap [2][32];
  int         frc [2][32];
  int         ncap [2] = '{0, 0};
  int         nb [2] = '{0, 0};
  int         rises [2] = '{0, 0};
  int         done_n [2] = '{0, 0};
  int         done_cyc [2] = '{0, 0};
  logic [7:0] bits [2];
  logic [1:0] psclk = 2'b00;

  always @(negedge sys_clk) begin
    for (int d = 0; d < 2; d++) begin
      automatic logic [7:0] nbits = {bits[d][6:0], mosi[d]};
      if (!sys_rst_n) begin
        nb[d] <= 0;
      end else if (sclk[d] && !psclk[d]) begin
        rises[d] <= rises[d] + 1;
        bits[d]  <= nbits;
        if (nb[d] == 0 && ncap[d] < 32) frc[d][ncap[d]] <= cyc;
        if (nb[d] == 7) begin
          if (ncap[d] < 32) cap[d][ncap[d]] <= {dc[d], nbits};
          ncap[d] <= ncap[d] + 1;
          nb[d]   <= 0;
        end else begin
          nb[d] <= nb[d] + 1;
        end
      end
      psclk[d] <= sclk[d];
      if (done_s[d]) begin
        done_n[d]   <= done_n[d] + 1;
        done_cyc[d] <= cyc;
      end
    end
  end

  int nchk = 0;
  int nerr = 0;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    nchk++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(negedge sys_clk);
    #1;
  endtask

  task automatic wait_cyc(input int t);
    while (cyc < t) step();
  endtask

  task automatic wait_idle(input int d);
    int k = 0;
    while (busy_s[d] && k < 200) begin
      step();
      k++;
    end
    check("idle_to", {31'b0, busy_s[d]}, 32'd0);
  endtask

  logic [8:0] gseq [8];

  // Generator: advances data 3 cycles after each wr_done
  task automatic gen(input int d, input int n);
    data_d[d] = gseq[0];
    en_d[d]   = 1'b1;
    for (int i = 0; i < n; i++) begin
      int k = 0;
      while (!done_s[d] && k < 400) begin
        step();
        k++;
      end
      check("gen_done", {31'b0, done_s[d]}, 32'd1);
      if (!done_s[d]) break;
      repeat (3) step();
      if (i < n - 1) data_d[d] = gseq[i + 1];
      else en_d[d] = 1'b0;
    end
  endtask

  int n, b, dn, rs;

  initial begin
    sys_rst_n = 1'b0;
    data_d[0] = '0;
    data_d[1] = '0;
    en_d      = 2'b00;
    repeat (3) step();
    check("rst_done", {31'b0, done_s[0]}, 32'd0);
    check("rst_busy", {31'b0, busy_s[0]}, 32'd0);
    check("rst_sclk", {31'b0, sclk[0]}, 32'd0);
    check("rst_mosi", {31'b0, mosi[0]}, 32'd0);
    check("rst_dc", {31'b0, dc[0]}, 32'd0);
    check("rst_csn", {31'b0, csn[0]}, 32'd1);
    sys_rst_n = 1'b1;
    repeat (2) step();

    // single command byte 02A
    n = cyc; b = ncap[0]; dn = done_n[0]; rs = rises[0];
    data_d[0] = 9'h02A; en_d[0] = 1'b1;
    step();
    en_d[0] = 1'b0;
    check("t1_csn", {31'b0, csn[0]}, 32'd0);
    check("t1_dc", {31'b0, dc[0]}, 32'd0);
    wait_cyc(n + 33);
    check("t1_done", {31'b0, done_s[0]}, 32'd1);
    wait_cyc(n + 37);
    check("t1_busy37", {31'b0, busy_s[0]}, 32'd1);
    wait_cyc(n + 38);
    check("t1_busy38", {31'b0, busy_s[0]}, 32'd0);
    check("t1_ncap", ncap[0] - b, 32'd1);
    check("t1_byte", {23'b0, cap[0][b]}, 32'h02A);
    check("t1_rises", rises[0] - rs, 32'd8);
    check("t1_ndone", done_n[0] - dn, 32'd1);
    check("t1_donecyc", done_cyc[0], n + 33);

    // 1EF held for two bytes
    step();
    n = cyc; b = ncap[0]; dn = done_n[0];
    data_d[0] = 9'h1EF; en_d[0] = 1'b1;
    wait_cyc(n + 38);
    check("t2_csn_gap", {31'b0, csn[0]}, 32'd0);
    wait_cyc(n + 39);
    en_d[0] = 1'b0;
    wait_cyc(n + 78);
    check("t2_ncap", ncap[0] - b, 32'd2);
    check("t2_b0", {23'b0, cap[0][b]}, 32'h1EF);
    check("t2_b1", {23'b0, cap[0][b + 1]}, 32'h1EF);
    check("t2_spacing", frc[0][b + 1] - frc[0][b], 32'd38);
    check("t2_ndone", done_n[0] - dn, 32'd2);

    // generator-paced sequence
    wait_idle(0);
    b = ncap[0];
    gseq[0] = 9'h02A; gseq[1] = 9'h100; gseq[2] = 9'h100;
    gseq[3] = 9'h100; gseq[4] = 9'h1EF;
    gen(0, 5);
    wait_idle(0);
    check("t3_ncap", ncap[0] - b, 32'd5);
    for (int i = 0; i < 5; i++)
      check($sformatf("t3_b%0d", i), {23'b0, cap[0][b + i]},
            {23'b0, gseq[i]});

    // en_write dropped 5 cycles into SHIFT
    step();
    n = cyc; dn = done_n[0]; rs = rises[0];
    data_d[0] = 9'h0C3; en_d[0] = 1'b1;
    wait_cyc(n + 6);
    en_d[0] = 1'b0;
    wait_cyc(n + 37);
    check("t4_csn37", {31'b0, csn[0]}, 32'd0);
    wait_cyc(n + 38);
    check("t4_csn38", {31'b0, csn[0]}, 32'd1);
    wait_cyc(n + 60);
    check("t4_rises", rises[0] - rs, 32'd8);
    check("t4_ndone", done_n[0] - dn, 32'd1);
    check("t4_busy", {31'b0, busy_s[0]}, 32'd0);

    // reset at SHIFT cycle 10
    n = cyc; b = ncap[0]; dn = done_n[0];
    data_d[0] = 9'h0F0; en_d[0] = 1'b1;
    step();
    en_d[0] = 1'b0;
    wait_cyc(n + 11);
    sys_rst_n = 1'b0;
    #1;
    check("t5_csn", {31'b0, csn[0]}, 32'd1);
    check("t5_sclk", {31'b0, sclk[0]}, 32'd0);
    check("t5_busy", {31'b0, busy_s[0]}, 32'd0);
    check("t5_done", {31'b0, done_s[0]}, 32'd0);
    step();
    sys_rst_n = 1'b1;
    repeat (40) step();
    check("t5_nodone", done_n[0] - dn, 32'd0);
    check("t5_nocap", ncap[0] - b, 32'd0);
    n = cyc;
    data_d[0] = 9'h155; en_d[0] = 1'b1;
    step();
    en_d[0] = 1'b0;
    wait_cyc(n + 40);
    check("t5_ncap", ncap[0] - b, 32'd1);
    check("t5_byte", {23'b0, cap[0][b]}, 32'h155);
    check("t5_ndone", done_n[0] - dn, 32'd1);

    // SCLK_DIV=1, GAP_CYCLES=2
    n = cyc; b = ncap[1];
    data_d[1] = 9'h0A5; en_d[1] = 1'b1;
    step();
    en_d[1] = 1'b0;
    wait_cyc(n + 2);
    check("t6_sclk", {31'b0, sclk[1]}, 32'd1);
    wait_cyc(n + 17);
    check("t6_done", {31'b0, done_s[1]}, 32'd1);
    wait_cyc(n + 19);
    check("t6_busy19", {31'b0, busy_s[1]}, 32'd1);
    wait_cyc(n + 20);
    check("t6_busy20", {31'b0, busy_s[1]}, 32'd0);
    check("t6_first", frc[1][b], n + 2);
    check("t6_byte", {23'b0, cap[1][b]}, 32'h0A5);
    b = ncap[1];
    gseq[0] = 9'h13C; gseq[1] = 9'h0FF; gseq[2] = 9'h101;
    gen(1, 3);
    wait_idle(1);
    check("t6_ncap", ncap[1] - b, 32'd3);
    for (int i = 0; i < 3; i++)
      check($sformatf("t6_b%0d", i), {23'b0, cap[1][b + i]},
            {23'b0, gseq[i]});

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
